ps2_mouse_init_ctrl: RTL and testbench
======================================

PS2_MOUSE_INIT_CTRL -- requirements
Module: ps2_mouse_init_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25_000_000, giving the per-wait timeout and the inter-byte packet gap limit (500 ms at 50 MHz).
REQ-002 SHALL have parameter MAX_RETRY, default 3, giving the maximum number of restarts of the init sequence before failure.
REQ-003 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  request to begin or restart mouse initialisation, level-sampled each cycle.
REQ-006 tx_data  out  8  command byte to the PS/2 byte transmitter.
REQ-007 tx_valid  out  1  tx_data valid; transfer occurs on a cycle with tx_valid&tx_ready.
REQ-008 tx_ready  in  1  transmitter can accept a byte.
REQ-009 rx_data  in  8  byte from the PS/2 byte receiver.
REQ-010 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-011 pkt  out  24  framed movement packet {byte0,byte1,byte2}, byte0 in [23:16].
REQ-012 pkt_valid  out  1  one-cycle strobe qualifying pkt.
REQ-013 busy  out  1  high while the init sequence is in progress.
REQ-014 streaming  out  1  high in STREAM.
REQ-015 error  out  1  high in FAIL.
REQ-016 retry_cnt  out  2  restarts consumed in the current init attempt.

Function
REQ-017 SHALL implement states IDLE, SEND_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK_EN, STREAM, FAIL.
REQ-018 IDLE/STREAM/FAIL with start=1 -> SEND_RST next cycle, retry_cnt cleared; start in any other state SHALL be ignored.
REQ-019 SEND_RST: tx_valid=1, tx_data=8'hFF, held stable until handshake; handshake cycle -> WAIT_ACK_RST.
REQ-020 WAIT_ACK_RST expects 8'hFA -> WAIT_BAT; WAIT_BAT expects 8'hAA -> WAIT_ID; WAIT_ID expects 8'h00 -> SEND_EN.
REQ-021 SEND_EN: tx_valid=1, tx_data=8'hF4 until handshake -> WAIT_ACK_EN; 8'hFA there -> STREAM.
REQ-022 tx_valid SHALL be 0 in every state except SEND_RST and SEND_EN; tx_data SHALL be 8'h00 when tx_valid=0.
REQ-023 Timeout counter SHALL clear on entry to each WAIT_* state and on every rx_valid; reaching TIMEOUT_CYCLES-1 without the expected byte is a fault.
REQ-024 Fault = timeout or any unexpected rx byte in a WAIT_* state (including 8'hFE/8'hFC).
REQ-025 On fault: if retry_cnt<MAX_RETRY, increment retry_cnt and go to SEND_RST; else go to FAIL (retry_cnt holds).
REQ-026 rx_valid coinciding with timeout expiry: the byte SHALL be evaluated and the timeout ignored.
REQ-027 rx_valid in IDLE, SEND_*, FAIL SHALL be discarded with no effect.
REQ-028 busy=1 in SEND_RST..WAIT_ACK_EN, else 0; busy, streaming and error SHALL be mutually exclusive.
REQ-029 STREAM framing: byte index 0..2; at index 0 a byte with rx_data[3]=0 SHALL be dropped (resync), index stays 0.
REQ-030 On the third byte, pkt SHALL be updated and pkt_valid pulsed for exactly one cycle, the cycle after that rx_valid; index wraps to 0.
REQ-031 In STREAM, a gap of TIMEOUT_CYCLES cycles with index≠0 SHALL reset index to 0 and discard the partial packet; STREAM is not left.
REQ-032 pkt SHALL hold its last value between pkt_valid pulses; restart via start SHALL reset index to 0 without clearing pkt.

Reset
REQ-033 reset=0 at a clock edge SHALL force IDLE, index 0, timeout counter 0, retry_cnt 0, pkt 24'h0, and all strobes/flags (tx_valid, pkt_valid, busy, streaming, error) 0, tx_data 8'h00, from any state including mid-handshake.
REQ-034 After reset release the block SHALL remain in IDLE until start=1.

Verification (bench: TIMEOUT_CYCLES=100, MAX_RETRY=3)
REQ-035 Nominal: start; accept FF; rx FA,AA,00; accept F4; rx FA -> streaming=1, busy=0, retry_cnt=0.
REQ-036 Stall/hold: tx_ready=0 for 20 cycles in SEND_RST -> tx_valid=1, tx_data=FF stable throughout; single handshake only.
REQ-037 Retry/fail: no responses -> FF resent 3 more times, 100 cycles apart after each handshake; 4th timeout -> error=1, retry_cnt=3; start -> SEND_RST, retry_cnt=0.
REQ-038 Bad byte: rx FE in WAIT_ACK_RST -> retry_cnt=1, FF resent next cycle.
REQ-039 Framing: in STREAM rx 02,09,05,FB -> 02 dropped; pkt=24'h0905FB, pkt_valid one cycle; rx 08,10 then 150 idle cycles then 08,01,02 -> pkt=24'h080102 only.
REQ-040 Reset mid-op: reset=0 during WAIT_BAT and during partial packet -> all outputs zero next cycle, state IDLE, start still required.

Source files
------------

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
//   Brings a PS/2 mouse from power-up to stream mode and then frames the
//   3-byte movement packets it sends. The init sequence is:
//   reset (FF) -> ACK (FA) -> self-test pass (AA) -> device ID (00)
//   -> enable reporting (F4) -> ACK (FA). Any timeout or unexpected byte
//   restarts the sequence, up to MAX_RETRY times, before giving up in FAIL.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   IDLE         | waiting for start
//   SEND_RST     | offering FF to the transmitter
//   WAIT_ACK_RST | waiting for FA after reset command
//   WAIT_BAT     | waiting for AA (self-test passed)
//   WAIT_ID      | waiting for device ID 00
//   SEND_EN      | offering F4 to the transmitter
//   WAIT_ACK_EN  | waiting for FA after enable command
//   STREAM       | mouse reporting; bytes framed into packets
//   FAIL         | retries exhausted, waiting for start
//
// Ports
//   CLOCK_50            sole clock, rising edge
//   reset               synchronous, active-low
//   start               begin/restart init (honoured in IDLE/STREAM/FAIL)
//   tx_data/tx_valid    command byte toward the PS/2 transmitter
//   tx_ready            transmitter accepts when high with tx_valid
//   rx_data/rx_valid    byte strobe from the PS/2 receiver
//   pkt/pkt_valid       framed movement packet, byte0 in [23:16]
//   busy/streaming/error status flags, mutually exclusive
//   retry_cnt           restarts consumed in the current attempt
module ps2_mouse_init_ctrl #(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [23:0] pkt,
  output logic        pkt_valid,
  output logic        busy,
  output logic        streaming,
  output logic        error,
  output logic [1:0]  retry_cnt
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  MAX_R    = 2'(MAX_RETRY);

  localparam logic [7:0] CMD_RST = 8'hFF;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_BAT = 8'hAA;
  localparam logic [7:0] RSP_ID  = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_RST,
    ST_WAIT_ACK_RST,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_SEND_EN,
    ST_WAIT_ACK_EN,
    ST_STREAM,
    ST_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tmo_cnt;
  logic [1:0]  idx;
  logic [7:0]  byte0, byte1;
  logic        fault;
  logic        timed;
  logic        tmo_tc;
  logic        restart;
  logic        retry_ok;

  assign timed = (state_q == ST_WAIT_ACK_RST) || (state_q == ST_WAIT_BAT) ||
                 (state_q == ST_WAIT_ID) || (state_q == ST_WAIT_ACK_EN) ||
                 (state_q == ST_STREAM);
  assign tmo_tc   = timed && (tmo_cnt == TMO_LAST);
  assign restart  = start && ((state_q == ST_IDLE) || (state_q == ST_STREAM) ||
                              (state_q == ST_FAIL));
  assign retry_ok = (retry_cnt < MAX_R);

  always_comb begin
    state_d   = state_q;
    fault     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b0;
    streaming = 1'b0;
    error     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SEND_RST;
      end
      ST_SEND_RST: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = CMD_RST;
        if (tx_ready) state_d = ST_WAIT_ACK_RST;
      end
      ST_WAIT_ACK_RST: begin
        busy = 1'b1;
        // A byte arriving on the timeout cycle wins over the timeout.
        if (rx_valid) begin
          if (rx_data == RSP_ACK) state_d = ST_WAIT_BAT;
          else                    fault   = 1'b1;
        end else if (tmo_tc) begin
          fault = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (rx_data == RSP_BAT) state_d = ST_WAIT_ID;
          else                    fault   = 1'b1;
        end else if (tmo_tc) begin
          fault = 1'b1;
        end
      end
      ST_WAIT_ID: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (rx_data == RSP_ID) state_d = ST_SEND_EN;
          else                   fault   = 1'b1;
        end else if (tmo_tc) begin
          fault = 1'b1;
        end
      end
      ST_SEND_EN: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = CMD_EN;
        if (tx_ready) state_d = ST_WAIT_ACK_EN;
      end
      ST_WAIT_ACK_EN: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (rx_data == RSP_ACK) state_d = ST_STREAM;
          else                    fault   = 1'b1;
        end else if (tmo_tc) begin
          fault = 1'b1;
        end
      end
      ST_STREAM: begin
        streaming = 1'b1;
        if (start) state_d = ST_SEND_RST;
      end
      ST_FAIL: begin
        error = 1'b1;
        if (start) state_d = ST_SEND_RST;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fault) state_d = retry_ok ? ST_SEND_RST : ST_FAIL;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      retry_cnt <= 2'd0;
      tmo_cnt   <= 32'd0;
      idx       <= 2'd0;
      byte0     <= 8'h00;
      byte1     <= 8'h00;
      pkt       <= 24'h0;
      pkt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_valid <= 1'b0;

      if (restart)                retry_cnt <= 2'd0;
      else if (fault && retry_ok) retry_cnt <= retry_cnt + 2'd1;

      // Every state change clears the timer, which covers entry to each
      // wait state; any received byte also restarts the gap measurement.
      if (rx_valid || (state_d != state_q) || tmo_tc || !timed)
        tmo_cnt <= 32'd0;
      else
        tmo_cnt <= tmo_cnt + 32'd1;

      if ((state_q != ST_STREAM) || start) begin
        idx <= 2'd0;
      end else if (rx_valid) begin
        case (idx)
          2'd0: begin
            // byte0 always has bit 3 set; anything else means we are
            // mid-packet, so drop it and keep hunting for a header.
            if (rx_data[3]) begin
              byte0 <= rx_data;
              idx   <= 2'd1;
            end
          end
          2'd1: begin
            byte1 <= rx_data;
            idx   <= 2'd2;
          end
          default: begin
            pkt       <= {byte0, byte1, rx_data};
            pkt_valid <= 1'b1;
            idx       <= 2'd0;
          end
        endcase
      end else if (tmo_tc) begin
        idx <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
module tb_ps2_mouse_init_ctrl;

  localparam int TMO = 100;
  localparam int MR  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [23:0] pkt;
  logic        pkt_valid;
  logic        busy;
  logic        streaming;
  logic        error;
  logic [1:0]  retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pkt = 0;

  logic [7:0]  exp_tx[$];
  logic [23:0] exp_pkt[$];

  always #5 clk = ~clk;

  ps2_mouse_init_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pkt       (pkt),
    .pkt_valid (pkt_valid),
    .busy      (busy),
    .streaming (streaming),
    .error     (error),
    .retry_cnt (retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: inputs change at posedge+1, so the negedge sees
  // exactly what the DUT will sample at the next rising edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                    chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
    end
    if (pkt_valid) begin
      n_pkt++;
      if (exp_pkt.size() == 0) chk("pkt_unexpected", {8'h0, pkt}, 32'hFFFF_FFFF);
      else                     chk("pkt", {8'h0, pkt}, {8'h0, exp_pkt.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_hs(input string tag);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (tx_valid && tx_ready) done = 1;
      tick(1);
    end
    if (!done) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic bring_up();
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hF4);
    pulse_start();
    wait_hs("hs_rst_timeout");
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_hs("hs_en_timeout");
    send_rx(8'hFA);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {27'h0, tx_valid, pkt_valid, busy, streaming, error}, 32'h0);
    chk({tag, "_txd"}, {24'h0, tx_data}, 32'h0);
    chk({tag, "_retry"}, {30'h0, retry_cnt}, 32'h0);
    chk({tag, "_pkt"}, {8'h0, pkt}, 32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(5);
    chk("idle_hold_busy", {31'h0, busy}, 32'd0);
    chk("idle_hold_txv", {31'h0, tx_valid}, 32'd0);

    // Nominal bring-up
    bring_up();
    chk("nom_streaming", {31'h0, streaming}, 32'd1);
    chk("nom_busy", {31'h0, busy}, 32'd0);
    chk("nom_retry", {30'h0, retry_cnt}, 32'd0);

    // Framing: 02 is not a header and is dropped
    exp_pkt.push_back(24'h0905FB);
    send_rx(8'h02);
    send_rx(8'h09);
    send_rx(8'h05);
    send_rx(8'hFB);
    chk("frame_pv_hi", {31'h0, pkt_valid}, 32'd1);
    chk("frame_pkt", {8'h0, pkt}, 32'h0905FB);
    tick(1);
    chk("frame_pv_lo", {31'h0, pkt_valid}, 32'd0);

    // Partial packet abandoned after an inter-byte gap
    send_rx(8'h08);
    send_rx(8'h10);
    tick(150);
    chk("gap_pkt_hold", {8'h0, pkt}, 32'h0905FB);
    chk("gap_streaming", {31'h0, streaming}, 32'd1);
    exp_pkt.push_back(24'h080102);
    send_rx(8'h08);
    send_rx(8'h01);
    send_rx(8'h02);
    chk("gap_pkt", {8'h0, pkt}, 32'h080102);
    tick(2);

    // Stall: FF must stay presented while the transmitter is not ready
    tx_ready = 1'b0;
    pulse_start();
    begin
      int unstable = 0;
      for (int i = 0; i < 20; i++) begin
        if (!(tx_valid === 1'b1 && tx_data === 8'hFF)) unstable++;
        tick(1);
      end
      chk("stall_unstable", unstable, 32'd0);
    end
    chk("stall_retry", {30'h0, retry_cnt}, 32'd0);
    exp_tx.push_back(8'hFF);
    tx_ready = 1'b1;
    wait_hs("hs_stall_timeout");
    chk("stall_txv_after", {31'h0, tx_valid}, 32'd0);

    // Bad byte in WAIT_ACK_RST: immediate resend
    exp_tx.push_back(8'hFF);
    send_rx(8'hFE);
    chk("bad_retry", {30'h0, retry_cnt}, 32'd1);
    chk("bad_txv", {31'h0, tx_valid}, 32'd1);
    chk("bad_txd", {24'h0, tx_data}, 32'hFF);
    wait_hs("hs_bad_timeout");

    // Retry to failure with no responses at all
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) exp_tx.push_back(8'hFF);
    pulse_start();
    wait_hs("hs_retry0_timeout");
    for (int k = 1; k <= 3; k++) begin
      tick(TMO - 1);
      chk("retry_early_txv", {31'h0, tx_valid}, 32'd0);
      tick(1);
      chk("retry_txv", {31'h0, tx_valid}, 32'd1);
      chk("retry_cnt", {30'h0, retry_cnt}, k);
      wait_hs("hs_retry_timeout");
    end
    tick(TMO - 1);
    chk("fail_early", {30'h0, busy, error}, 32'b10);
    tick(1);
    chk("fail_flags", {29'h0, busy, streaming, error}, 32'b001);
    chk("fail_retry", {30'h0, retry_cnt}, 32'd3);
    chk("fail_txv", {31'h0, tx_valid}, 32'd0);
    exp_tx.push_back(8'hFF);
    pulse_start();
    chk("restart_flags", {29'h0, busy, streaming, error}, 32'b100);
    chk("restart_retry", {30'h0, retry_cnt}, 32'd0);
    chk("restart_txd", {24'h0, tx_data}, 32'hFF);
    wait_hs("hs_restart_timeout");

    // Reset during WAIT_BAT
    send_rx(8'hFA);
    chk("wbat_busy", {31'h0, busy}, 32'd1);
    reset = 1'b0;
    tick(1);
    chk_all_zero("rst_wbat");
    reset = 1'b1;
    tick(5);
    chk("rst_wbat_idle", {30'h0, busy, tx_valid}, 32'd0);

    // Reset during a partial packet
    bring_up();
    exp_pkt.push_back(24'h0905FB);
    send_rx(8'h09);
    send_rx(8'h05);
    send_rx(8'hFB);
    send_rx(8'h08);
    send_rx(8'h10);
    reset = 1'b0;
    tick(1);
    chk_all_zero("rst_pkt");
    reset = 1'b1;
    tick(5);
    chk("rst_pkt_idle", {29'h0, busy, streaming, error}, 32'd0);

    // Restart via start drops partial packet but keeps pkt
    bring_up();
    exp_pkt.push_back(24'h0905FB);
    send_rx(8'h09);
    send_rx(8'h05);
    send_rx(8'hFB);
    send_rx(8'h08);
    bring_up();
    chk("restart_pkt_hold", {8'h0, pkt}, 32'h0905FB);
    exp_pkt.push_back(24'h080102);
    send_rx(8'h08);
    send_rx(8'h01);
    send_rx(8'h02);
    tick(2);

    chk("tx_queue_left", exp_tx.size(), 32'd0);
    chk("pkt_queue_left", exp_pkt.size(), 32'd0);
    chk("pkt_count", n_pkt, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
